serial_word_comparator: RTL and testbench

- Multi-cycle magnitude comparator for two unsigned WIDTH-bit words.
- Serializes both words MSB-first and resolves equal / greater / less one bit pair per cycle, using the same decision rule as our 1-bit comparator.
- Upstream: valid/ready operand handshake. Downstream: valid/ready result handshake with one-hot eq/gt/lt flags.
- Sits in the datapath where a parallel N-bit comparator costs too much area.

---
 rtl/serial_word_comparator.sv | 119 +++++++++++
 tb/tb_serial_word_comparator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_word_comparator.sv
// serial_word_comparator: bit-serial MSB-first magnitude comparator.
// Both operands are shifted out MSB-first. The first bit pair that differs
// decides the result, and later bits are ignored.
// Optional build macro SERIAL_WORD_COMPARATOR_EARLY_EXIT_EN: when it is defined,
// the block leaves SHIFT on the cycle the result is decided instead of
// shifting all WIDTH bits. The result flags are the same either way.
module serial_word_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_equals_b,
    output logic             a_greater_b,
    output logic             a_less_b
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic [CW-1:0]    cnt_q;
    logic             decided_q, gt_q, lt_q;
    logic             in_ready_q, out_valid_q, eq_out_q, gt_out_q, lt_out_q;

    logic             sa_msb, sb_msb;
    logic             decided_d, gt_d, lt_d, finish_d;

    // One step of the 1-bit comparator rule. The first differing pair latches gt/lt.
    always_comb begin
        sa_msb    = sa_q[WIDTH-1];
        sb_msb    = sb_q[WIDTH-1];
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        if (!decided_q && (sa_msb != sb_msb)) begin
            decided_d = 1'b1;
            gt_d      = sa_msb & ~sb_msb;
            lt_d      = ~sa_msb & sb_msb;
        end
`ifdef SERIAL_WORD_COMPARATOR_EARLY_EXIT_EN
        finish_d = (cnt_q == '0) || (decided_d && !decided_q);
`else
        finish_d = (cnt_q == '0);
`endif
    end

    // Control FSM with registered handshake signals and result flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            cnt_q       <= '0;
            decided_q   <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            eq_out_q    <= 1'b0;
            gt_out_q    <= 1'b0;
            lt_out_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sa_q       <= a;
                        sb_q       <= b;
                        cnt_q      <= CW'(WIDTH - 1);
                        decided_q  <= 1'b0;
                        gt_q       <= 1'b0;
                        lt_q       <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa_q      <= {sa_q[WIDTH-2:0], 1'b0};
                    sb_q      <= {sb_q[WIDTH-2:0], 1'b0};
                    cnt_q     <= cnt_q - 1'b1;
                    decided_q <= decided_d;
                    gt_q      <= gt_d;
                    lt_q      <= lt_d;
                    if (finish_d) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        eq_out_q    <= ~decided_d;
                        gt_out_q    <= gt_d;
                        lt_out_q    <= lt_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        eq_out_q    <= 1'b0;
                        gt_out_q    <= 1'b0;
                        lt_out_q    <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign a_equals_b  = eq_out_q;
    assign a_greater_b = gt_out_q;
    assign a_less_b    = lt_out_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Testbench for serial_word_comparator with WIDTH=8.
// A protocol-level model predicts the outputs on every cycle. Directed
// transactions also check hand-computed flags and latencies.
module tb_serial_word_comparator;
    localparam int W = 8;
`ifdef SERIAL_WORD_COMPARATOR_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b;
    logic         eq, gt, lt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    serial_word_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .a_equals_b(eq), .a_greater_b(gt), .a_less_b(lt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Latency for one transaction, computed from the operands.
    function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        int hi;
        d  = x ^ y;
        hi = -1;
        for (int i = 0; i < W; i++) if (d[i]) hi = i;
        if (hi < 0 || !EE) return W;
        return W - hi;
    endfunction

    // Model phases: 0 = idle, 1 = busy, 2 = result presented.
    int   m_phase = 0;
    int   m_left  = 0;
    logic m_eq, m_gt, m_lt;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_eq    = (a == b);
                    m_gt    = (a > b);
                    m_lt    = (a < b);
                    m_left  = model_lat(a, b);
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Compare the outputs against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en)
            check("cycle {in_ready,out_valid,eq,gt,lt}",
                  {27'd0, in_ready, out_valid, eq, gt, lt},
                  {27'd0, m_phase == 0, m_phase == 2,
                   (m_phase == 2) ? {m_eq, m_gt, m_lt} : 3'b000});
    end

    // Run one transaction from IDLE with out_ready held high. Checks the
    // literal latency and flags, then checks that the block returns to IDLE.
    task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input int exp_lat, input logic [2:0] exp_f, input string nm);
        int lat;
        bit got;
        a = ta; b = tb_v; in_valid = 1; out_ready = 1;
        lat = 0; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            in_valid = 0;
            if (out_valid) got = 1; else lat++;
        end
        check({nm, " latency"}, got ? lat : 32'hFFFF_FFFF, exp_lat);
        check({nm, " flags"}, {29'd0, eq, gt, lt}, {29'd0, exp_f});
        @(negedge clk);
        check({nm, " idle after handshake"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int  lat;
        bit  got;
        rst_n = 0; in_valid = 0; out_ready = 0; a = '0; b = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check("reset state", {27'd0, in_ready, out_valid, eq, gt, lt}, 32'h10);
        rst_n = 1;
        @(negedge clk);

        txn(8'hA5, 8'hA5, 8,               3'b100, "equal A5");
        txn(8'h00, 8'h00, 8,               3'b100, "equal 00");
        txn(8'hFF, 8'hFF, 8,               3'b100, "equal FF");
        txn(8'h80, 8'h7F, EE ? 1 : 8,      3'b010, "msb 80>7F");
        txn(8'h01, 8'h02, EE ? 7 : 8,      3'b001, "low 01<02");
        txn(8'hFF, 8'h00, EE ? 1 : 8,      3'b010, "FF>00");

        // Backpressure: hold the result for 5 cycles while a new request is offered.
        a = 8'h3C; b = 8'h3D; in_valid = 1; out_ready = 0;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            in_valid = 0;
            if (out_valid) got = 1;
        end
        check("bp result seen", {31'd0, got}, 32'd1);
        a = 8'h00; b = 8'hFF; in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp hold", {27'd0, in_ready, out_valid, eq, gt, lt}, 32'h09);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        check("bp released", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset during the 3rd SHIFT cycle, with in_valid high during reset.
        a = 8'h12; b = 8'h13; in_valid = 1; out_ready = 1;
        @(negedge clk); in_valid = 0;
        @(negedge clk);
        @(negedge clk); rst_n = 0; in_valid = 1; a = 8'hFF; b = 8'h00;
        @(negedge clk);
        check("mid reset", {27'd0, in_ready, out_valid, eq, gt, lt}, 32'h10);
        @(negedge clk); rst_n = 1; in_valid = 0;
        @(negedge clk);
        check("reset not latched", {30'd0, in_ready, out_valid}, 32'd2);
        txn(8'h10, 8'h20, EE ? 3 : 8, 3'b001, "after reset 10<20");

        // Back-to-back: in_valid stays high, so the next accept follows the handshake.
        a = 8'h33; b = 8'h34; in_valid = 1; out_ready = 1;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1; else begin a = 8'h33; b = 8'h34; end
        end
        check("b2b first flags", {29'd0, eq, gt, lt}, 32'd1);
        a = 8'hC0; b = 8'h0F;
        @(negedge clk);
        check("b2b idle one cycle", {30'd0, in_ready, out_valid}, 32'd2);
        @(negedge clk);
        check("b2b second accepted", {31'd0, in_ready}, 32'd0);
        in_valid = 0;
        lat = 1; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1; else lat++;
        end
        check("b2b second latency", got ? lat : 32'hFFFF_FFFF, EE ? 1 : 8);
        check("b2b second flags", {29'd0, eq, gt, lt}, 32'd2);
        @(negedge clk);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
